// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO op controller.
package hilo_pkg;

    localparam int unsigned HILO_DATA_W = 32;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

endpackage

// File: rtl/hilo_op_timer.sv
// Watchdog counter for the WAIT phase; expired_o flags the last allowed cycle.
module hilo_op_timer #(
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Next count: clear wins over enable; expiry is pre-computed so the flag is a flop.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
        expired_d = (count_d == LAST);
    end

    // Counter and expiry registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/hilo_op_ctrl.sv
// Sequences MULT/DIV units, executes MTHI/MTLO and owns architectural HI/LO.
module hilo_op_ctrl
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_W  = HILO_DATA_W,
    parameter int unsigned TIMEOUT = 40,
    parameter int unsigned CNT_W   = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              flush,
    output logic              ready,
    output logic              busy,
    output logic [DATA_W-1:0] unit_a,
    output logic [DATA_W-1:0] unit_b,
    output logic              mul_start,
    output logic              div_start,
    input  logic [DATA_W-1:0] mul_hi,
    input  logic [DATA_W-1:0] mul_lo,
    input  logic              mul_done,
    input  logic [DATA_W-1:0] div_hi,
    input  logic [DATA_W-1:0] div_lo,
    input  logic              div_done,
    input  logic              div_zero,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              done,
    output logic              exc_div0,
    output logic              exc_timeout
);

    state_e            state_q;
    op_e               op_q;
    op_e               op_in;
    logic [DATA_W-1:0] unit_a_q, unit_b_q, hi_q, lo_q;
    logic              ready_q, busy_q;
    logic              mul_start_q, div_start_q;
    logic              done_q, exc_div0_q, exc_timeout_q;

    logic              tmr_clr, tmr_en, tmr_expired;
    logic              sel_done;
    logic [DATA_W-1:0] sel_hi, sel_lo;

    assign op_in   = op_e'(op);
    assign tmr_clr = (state_q == ST_START);
    assign tmr_en  = (state_q == ST_WAIT);

    hilo_op_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_expired)
    );

    // Route completion and results from whichever unit owns the in-flight op.
    always_comb begin
        sel_done = mul_done;
        sel_hi   = mul_hi;
        sel_lo   = mul_lo;
        if (op_q == OP_DIV) begin
            sel_done = div_done;
            sel_hi   = div_hi;
            sel_lo   = div_lo;
        end
    end

    // Op sequencer: state, operand latches, HI/LO and all pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MULT;
            unit_a_q      <= '0;
            unit_b_q      <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            mul_start_q   <= 1'b0;
            div_start_q   <= 1'b0;
            done_q        <= 1'b0;
            exc_div0_q    <= 1'b0;
            exc_timeout_q <= 1'b0;
        end else begin
            mul_start_q   <= 1'b0;
            div_start_q   <= 1'b0;
            done_q        <= 1'b0;
            exc_div0_q    <= 1'b0;
            exc_timeout_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        case (op_in)
                            OP_MTHI: begin
                                hi_q    <= a;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                            OP_MTLO: begin
                                lo_q    <= a;
                                done_q  <= 1'b1;
                                state_q <= ST_DONE;
                            end
                            default: begin
                                unit_a_q    <= a;
                                unit_b_q    <= b;
                                op_q        <= op_in;
                                mul_start_q <= (op_in == OP_MULT);
                                div_start_q <= (op_in == OP_DIV);
                                state_q     <= ST_START;
                            end
                        endcase
                    end
                end
                ST_START: begin
                    // Unit done levels are stale here and deliberately not looked at.
                    if (flush) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (op_q == OP_DIV && div_zero) begin
                        done_q     <= 1'b1;
                        exc_div0_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (sel_done) begin
                        hi_q    <= sel_hi;
                        lo_q    <= sel_lo;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else if (tmr_expired) begin
                        done_q        <= 1'b1;
                        exc_timeout_q <= 1'b1;
                        state_q       <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign unit_a      = unit_a_q;
    assign unit_b      = unit_b_q;
    assign mul_start   = mul_start_q;
    // The divider's zero flag only settles once unit_b is latched, so it gates the pulse.
    assign div_start   = div_start_q & ~div_zero;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign done        = done_q;
    assign exc_div0    = exc_div0_q;
    assign exc_timeout = exc_timeout_q;

endmodule
